// File: rtl/uart_pkg.sv
// uart_pkg: register map, bit positions and TX FSM encoding
// shared by the UART MMIO front end.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RXCNT  = 2'd3;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_OVR   = 2;
    localparam int ST_TX_IDLE  = 3;
    localparam int ST_IRQ      = 7;

    localparam int CT_RX_IE = 0;
    localparam int CT_TX_IE = 1;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_e;

    // A full 256-deep FIFO has a 9-bit count; clamp it into one byte.
    function automatic logic [7:0] sat_cnt(input logic [8:0] c);
        return c[8] ? 8'hFF : c[7:0];
    endfunction

endpackage

// File: rtl/uart_mmio_fifo_if.sv
// uart_mmio_fifo_if: CPU-side register bus of the UART front end,
// master = address decoder / CPU, slave = uart_mmio_fifo.
interface uart_mmio_fifo_if;

    logic       cs;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq_n;

    modport master (
        output cs, we, addr, wdata,
        input  rdata, irq_n
    );

    modport slave (
        input  cs, we, addr, wdata,
        output rdata, irq_n
    );

endinterface

// File: rtl/uart_mmio_fifo_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO, power-of-two depth.
// A pop frees a slot for a push in the same cycle, even when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: 6502 register front end for the UART core.
// RX/TX byte FIFOs, TX drain FSM and registered level interrupt.
module uart_mmio_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    uart_mmio_fifo_if.slave bus,
    input  logic [7:0]      uart_rx_data,
    input  logic            uart_rx_ready,
    output logic [7:0]      uart_tx_data,
    output logic            uart_tx_start,
    input  logic            uart_tx_busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          rd_acc, wr_acc;
    logic          rx_pop, rx_drop;
    logic          rx_full, rx_empty;
    logic [7:0]    rx_dout;
    logic [CW-1:0] rx_count;
    logic          tx_push, tx_pop;
    logic          tx_full, tx_empty;
    logic [7:0]    tx_dout;
    logic [CW-1:0] tx_count;
    logic [7:0]    tx_nxt_head;
    logic [1:0]    ctrl_q;
    logic          rx_ovr_q;
    logic          tx_idle, irq;
    logic [7:0]    status;
    logic [7:0]    rd_mux;
    tx_state_e     state_q, state_d;

    assign rd_acc  = bus.cs & ~bus.we;
    assign wr_acc  = bus.cs & bus.we;
    assign rx_pop  = rd_acc & (bus.addr == REG_DATA) & ~rx_empty;
    assign rx_drop = uart_rx_ready & rx_full & ~rx_pop;
    assign tx_push = wr_acc & (bus.addr == REG_DATA) & ~tx_full;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (uart_rx_ready),
        .pop     (rx_pop),
        .din     (uart_rx_data),
        .dout    (rx_dout),
        .count   (rx_count),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tx_push),
        .pop     (tx_pop),
        .din     (bus.wdata),
        .dout    (tx_dout),
        .count   (tx_count),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign tx_idle = (tx_count == '0) & (state_q == TX_IDLE)
                   & ~uart_tx_busy;
    assign irq = (ctrl_q[CT_RX_IE] & ~rx_empty)
               | (ctrl_q[CT_TX_IE] & tx_idle);

    always_comb begin
        status              = '0;
        status[ST_RX_AVAIL] = ~rx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_OVR]   = rx_ovr_q;
        status[ST_TX_IDLE]  = tx_idle;
        status[ST_IRQ]      = irq;
    end

    always_comb begin
        rd_mux = '0;
        unique case (bus.addr)
            REG_DATA:   rd_mux = rx_empty ? 8'h00 : rx_dout;
            REG_STATUS: rd_mux = status;
            REG_CTRL:   rd_mux = {6'b0, ctrl_q};
            REG_RXCNT:  rd_mux = sat_cnt(9'(rx_count));
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rdata <= '0;
            bus.irq_n <= 1'b1;
            ctrl_q    <= '0;
            rx_ovr_q  <= 1'b0;
        end else begin
            bus.irq_n <= ~irq;
            if (rd_acc) bus.rdata <= rd_mux;
            if (wr_acc && bus.addr == REG_CTRL)
                ctrl_q <= bus.wdata[1:0];
            // A new drop outranks a simultaneous clear.
            if (rx_drop)
                rx_ovr_q <= 1'b1;
            else if (wr_acc && bus.addr == REG_STATUS)
                rx_ovr_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_pop  = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (!tx_empty && !uart_tx_busy) begin
                    tx_pop  = 1'b1;
                    state_d = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: if (uart_tx_busy)  state_d = TX_WAIT_DONE;
            TX_WAIT_DONE: if (!uart_tx_busy) state_d = TX_IDLE;
            default:      state_d = TX_IDLE;
        endcase
    end

    assign uart_tx_start = tx_pop;

    // Pre-load the byte that will be at the head while idle, so the
    // launch cycle already presents it on the registered data output.
    assign tx_nxt_head = !tx_empty ? tx_dout
                       : (tx_push ? bus.wdata : uart_tx_data);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= TX_IDLE;
            uart_tx_data <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == TX_IDLE) uart_tx_data <= tx_nxt_head;
        end
    end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// tb_uart_mmio_fifo: directed checks of the UART MMIO front end
// against a simple transmitter-core model.
module tb_uart_mmio_fifo;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] uart_rx_data = '0;
    logic       uart_rx_ready = 1'b0;
    logic [7:0] uart_tx_data;
    logic       uart_tx_start;
    logic       uart_tx_busy;

    int         n_cmp = 0;
    int         n_err = 0;
    logic       hold_busy = 1'b0;
    int         busy_len = 4340;
    int         busy_cnt = 0;
    logic       busy_prev = 1'b0;
    logic       gap_chk = 1'b0;
    int         viol = 0;
    logic [7:0] txlog [$];
    logic [7:0] rd;

    uart_mmio_fifo_if bus();

    uart_mmio_fifo #(.DEPTH(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_start (uart_tx_start),
        .uart_tx_busy  (uart_tx_busy)
    );

    always #10 clk = ~clk;

    // Core model: busy rises the cycle after start, lasts busy_len cycles.
    assign uart_tx_busy = hold_busy | (busy_cnt != 0);

    always @(posedge clk) begin
        if (uart_tx_start) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        busy_prev <= uart_tx_busy;
        if (reset_n && uart_tx_start) begin
            txlog.push_back(uart_tx_data);
            if (uart_tx_busy || (gap_chk && busy_prev)) viol <= viol + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
        @(negedge clk);
        bus.cs = 1'b0;
        d = bus.rdata;
    endtask

    task automatic rx_push(input logic [7:0] d);
        @(negedge clk);
        uart_rx_ready = 1'b1; uart_rx_data = d;
        @(negedge clk);
        uart_rx_ready = 1'b0;
    endtask

    task automatic set_hold(input logic v);
        @(posedge clk);
        #1 hold_busy = v;
    endtask

    // Wait for n launches, then for the last byte to finish in the core.
    task automatic wait_tx(input int n, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (txlog.size() >= n) break;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!uart_tx_busy) break;
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_rdata", bus.rdata, 8'h00);
        chk("rst_irq_n", bus.irq_n, 1'b1);
        chk("rst_tx_data", uart_tx_data, 8'h00);
        chk("rst_tx_start", uart_tx_start, 1'b0);
        bus_read(2'd1, rd); chk("rst_status", rd, 8'h08);
        bus_read(2'd3, rd); chk("rst_rxcnt", rd, 8'h00);

        rx_push(8'h41); rx_push(8'h42); rx_push(8'h43);
        bus_read(2'd3, rd); chk("burst_rxcnt", rd, 8'h03);
        bus_read(2'd0, rd); chk("burst_d0", rd, 8'h41);
        bus_read(2'd0, rd); chk("burst_d1", rd, 8'h42);
        bus_read(2'd0, rd); chk("burst_d2", rd, 8'h43);
        bus_read(2'd0, rd); chk("burst_empty", rd, 8'h00);
        bus_read(2'd3, rd); chk("burst_rxcnt0", rd, 8'h00);

        for (int i = 0; i <= 16; i++) rx_push(8'(i));
        bus_read(2'd1, rd); chk("ovr_status", rd, 8'h0D);
        bus_read(2'd3, rd); chk("ovr_rxcnt", rd, 8'h10);
        bus_write(2'd1, 8'h00);
        bus_read(2'd1, rd); chk("ovr_clear", rd, 8'h09);
        bus_read(2'd0, rd); chk("ovr_first", rd, 8'h00);
        for (int i = 1; i < 16; i++) bus_read(2'd0, rd);
        chk("ovr_last", rd, 8'h0F);
        bus_read(2'd3, rd); chk("ovr_rxcnt0", rd, 8'h00);

        gap_chk = 1'b1;
        txlog.delete();
        bus_write(2'd0, 8'h55);
        chk("drain_start_n1", uart_tx_start, 1'b1);
        chk("drain_data_n1", uart_tx_data, 8'h55);
        bus_write(2'd0, 8'hAA);
        bus_write(2'd0, 8'h0D);
        wait_tx(3, 20000);
        chk("drain_count", txlog.size(), 3);
        chk("drain_b0", txlog[0], 8'h55);
        chk("drain_b1", txlog[1], 8'hAA);
        chk("drain_b2", txlog[2], 8'h0D);
        chk("drain_gap", viol, 0);
        bus_read(2'd1, rd); chk("drain_status", rd, 8'h08);

        gap_chk = 1'b0;
        busy_len = 20;
        txlog.delete();
        set_hold(1'b1);
        for (int i = 0; i < 15; i++) bus_write(2'd0, 8'h80 + 8'(i));
        bus_read(2'd1, rd); chk("full_15", rd, 8'h00);
        bus_write(2'd0, 8'h8F);
        bus_read(2'd1, rd); chk("full_16", rd, 8'h02);
        bus_write(2'd0, 8'hFF);
        bus_read(2'd1, rd); chk("full_17", rd, 8'h02);
        set_hold(1'b0);
        wait_tx(16, 3000);
        chk("full_count", txlog.size(), 16);
        chk("full_first", txlog[0], 8'h80);
        chk("full_last", txlog[15], 8'h8F);
        chk("full_busy", viol, 0);

        bus_write(2'd2, 8'h01);
        bus_read(2'd2, rd); chk("irq_ctrl", rd, 8'h01);
        rx_push(8'h7E);
        chk("irq_lag", bus.irq_n, 1'b1);
        @(negedge clk);
        chk("irq_low", bus.irq_n, 1'b0);
        bus_read(2'd1, rd); chk("irq_status", rd, 8'h89);
        bus_read(2'd0, rd); chk("irq_data", rd, 8'h7E);
        chk("irq_hold", bus.irq_n, 1'b0);
        @(negedge clk);
        chk("irq_high", bus.irq_n, 1'b1);
        bus_write(2'd2, 8'hFF);
        bus_read(2'd2, rd); chk("ctrl_mask", rd, 8'h03);
        chk("irq_txie", bus.irq_n, 1'b0);

        busy_len = 200;
        bus_write(2'd2, 8'h01);
        rx_push(8'h11); rx_push(8'h22);
        txlog.delete();
        bus_write(2'd0, 8'h31);
        bus_write(2'd0, 8'h32);
        bus_write(2'd0, 8'h33);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txlog.size() >= 1) break;
        end
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rdata", bus.rdata, 8'h00);
        chk("mid_irq_n", bus.irq_n, 1'b1);
        chk("mid_tx_data", uart_tx_data, 8'h00);
        chk("mid_tx_start", uart_tx_start, 1'b0);
        bus_read(2'd3, rd); chk("mid_rxcnt", rd, 8'h00);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!uart_tx_busy) break;
        end
        repeat (3) @(negedge clk);
        bus_read(2'd1, rd); chk("mid_status", rd, 8'h08);
        repeat (50) @(negedge clk);
        chk("mid_count", txlog.size(), 1);
        chk("mid_byte", txlog[0], 8'h31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
